// File: rtl/bsg_async_fifo_wptr_gray_pkg.sv
// Shared sizing for the async FIFO write-pointer slice.
// Combinational helpers only; no latency.
// No flow control of its own.
package bsg_async_fifo_wptr_gray_pkg;

  localparam int default_lg_size_lp = 3;

  // Pointers carry one extra wrap bit beyond the storage address.
  function automatic int ptr_width(input int lg_size);
    return lg_size + 1;
  endfunction

endpackage

// File: rtl/bsg_binary_to_gray.sv
// Binary to reflected Gray code converter.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module bsg_binary_to_gray #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  assign o = i ^ (i >> 1);

endmodule

// File: rtl/bsg_gray_to_binary.sv
// Reflected Gray code to binary converter.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module bsg_gray_to_binary #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar k = 0; k < width_p; k++) begin : g_bit
    assign o[k] = ^i[width_p-1:k];
  end

endmodule

// File: rtl/bsg_async_fifo_wptr_gray.sv
// Write-side async FIFO pointer: binary/Gray write pointer, registered full, occupancy.
// Latency: one cycle from accepted write to pointer/full update; used_o combinational in read ptr.
// Backpressure: w_ready_o = ~full_o; writes offered while full are dropped.
module bsg_async_fifo_wptr_gray
  import bsg_async_fifo_wptr_gray_pkg::*;
#(
  parameter int lg_size_p = default_lg_size_lp
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 w_v_i,
  output logic                 w_ready_o,
  output logic [lg_size_p-1:0] w_addr_o,
  output logic [lg_size_p:0]   w_ptr_gray_o,
  input  logic [lg_size_p:0]   r_ptr_gray_sync_i,
  output logic                 full_o,
  output logic [lg_size_p:0]   used_o
);

  localparam int ptr_width_lp = ptr_width(lg_size_p);

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the read pointer with its top two bits inverted.
  localparam logic [ptr_width_lp-1:0] full_mask_lp = ~({ptr_width_lp{1'b1}} >> 2);

  logic [ptr_width_lp-1:0] wbin_r, wbin_n;
  logic [ptr_width_lp-1:0] wgray_r, wgray_n;
  logic                    full_r, full_n;
  logic [ptr_width_lp-1:0] rbin;
  logic                    accept;

  assign accept = w_v_i & ~full_r;
  assign wbin_n = wbin_r + {{(ptr_width_lp-1){1'b0}}, accept};

  bsg_binary_to_gray #(.width_p(ptr_width_lp)) wgray_conv (
    .i(wbin_n),
    .o(wgray_n)
  );

  bsg_gray_to_binary #(.width_p(ptr_width_lp)) rbin_conv (
    .i(r_ptr_gray_sync_i),
    .o(rbin)
  );

  assign full_n = (wgray_n == (r_ptr_gray_sync_i ^ full_mask_lp));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wbin_r  <= '0;
      wgray_r <= '0;
      full_r  <= 1'b0;
    end else begin
      wbin_r  <= wbin_n;
      wgray_r <= wgray_n;
      full_r  <= full_n;
    end
  end

  assign w_ready_o    = ~full_r;
  assign full_o       = full_r;
  assign w_addr_o     = wbin_r[lg_size_p-1:0];
  assign w_ptr_gray_o = wgray_r;
  assign used_o       = wbin_r - rbin;

endmodule

// File: tb/tb_bsg_async_fifo_wptr_gray.sv
// Directed bench for the async FIFO write-pointer block, lg_size_p = 3.
// Stimulus pushes hand-computed per-cycle expectations; a negedge monitor checks them.
module tb_bsg_async_fifo_wptr_gray;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       w_v_i = 1'b1;
  logic       w_ready_o;
  logic [2:0] w_addr_o;
  logic [3:0] w_ptr_gray_o;
  logic [3:0] r_ptr_gray_sync_i = 4'b0000;
  logic       full_o;
  logic [3:0] used_o;

  bsg_async_fifo_wptr_gray #(.lg_size_p(3)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .w_v_i(w_v_i),
    .w_ready_o(w_ready_o),
    .w_addr_o(w_addr_o),
    .w_ptr_gray_o(w_ptr_gray_o),
    .r_ptr_gray_sync_i(r_ptr_gray_sync_i),
    .full_o(full_o),
    .used_o(used_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic [3:0] used;
    logic       step;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] prev_gray = 4'b0000;
  logic [3:0] gt [0:16];

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc_cnt, act, req);
    end
  endtask

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk_i) begin
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc_cnt) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("w_addr_o", {1'b0, w_addr_o}, {1'b0, e.addr});
      chk("w_ptr_gray_o", w_ptr_gray_o, e.gray);
      chk("full_o", {3'b0, full_o}, {3'b0, e.full});
      chk("w_ready_o", {3'b0, w_ready_o}, {3'b0, ~e.full});
      chk("used_o", used_o, e.used);
      if (e.step)
        chk("gray_one_bit_step", 4'($countones(w_ptr_gray_o ^ prev_gray)), 4'd1);
    end
    prev_gray <= w_ptr_gray_o;
  end

  // Drive one cycle of inputs; optionally queue the outputs expected during it.
  task automatic cyc(input logic rst, input logic v, input logic [3:0] r, input logic en,
                     input logic [2:0] ea, input logic [3:0] eg, input logic ef,
                     input logic [3:0] eu, input logic step = 1'b0);
    exp_t e;
    @(posedge clk_i);
    #1;
    reset_i = rst;
    w_v_i = v;
    r_ptr_gray_sync_i = r;
    if (en) begin
      e.cyc = cyc_cnt; e.addr = ea; e.gray = eg; e.full = ef; e.used = eu; e.step = step;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    gt[0] = 4'b0000; gt[1] = 4'b0001; gt[2] = 4'b0011; gt[3] = 4'b0010;
    gt[4] = 4'b0110; gt[5] = 4'b0111; gt[6] = 4'b0101; gt[7] = 4'b0100;
    gt[8] = 4'b1100; gt[9] = 4'b1101; gt[10] = 4'b1111; gt[11] = 4'b1110;
    gt[12] = 4'b1010; gt[13] = 4'b1011; gt[14] = 4'b1001; gt[15] = 4'b1000;
    gt[16] = 4'b0000;

    // Reset held two edges with w_v_i high; pointer must stay at zero.
    cyc(1, 1, 4'b0000, 1, 3'd0, 4'b0000, 0, 4'd0);
    cyc(0, 0, 4'b0000, 1, 3'd0, 4'b0000, 0, 4'd0);

    // Fill eight slots against a read pointer of zero.
    for (int k = 0; k < 8; k++)
      cyc(0, 1, 4'b0000, 1, 3'(k), gt[k], 0, 4'(k));
    cyc(0, 1, 4'b0000, 1, 3'd0, 4'b1100, 1, 4'd8);
    cyc(0, 0, 4'b0000, 1, 3'd0, 4'b1100, 1, 4'd8);

    // Drain one: used drops immediately, full clears an edge later.
    cyc(0, 0, 4'b0001, 1, 3'd0, 4'b1100, 1, 4'd7);
    cyc(0, 1, 4'b0001, 1, 3'd0, 4'b1100, 0, 4'd7);
    cyc(0, 0, 4'b0001, 1, 3'd1, 4'b1101, 1, 4'd8);

    // Wrap: 16 writes with the read pointer trailing by two.
    cyc(1, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'd0);
    for (int k = 0; k < 16; k++)
      cyc(0, 1, (k < 2) ? 4'b0000 : gt[k-2], 1, 3'(k), gt[k], 0,
          (k < 2) ? 4'(k) : 4'd2, k > 0);
    cyc(0, 1, gt[14], 1, 3'd0, 4'b0000, 0, 4'd2, 1'b1);

    // Wrapped occupancy: wbin 0001 against read binary 1010.
    cyc(0, 0, 4'b1111, 1, 3'd1, 4'b0001, 0, 4'd7);

    // Occupancy 5 - 2, then reset mid-fill together with a write.
    cyc(1, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'd0);
    for (int k = 0; k < 5; k++)
      cyc(0, 1, 4'b0000, 1, 3'(k), gt[k], 0, 4'(k));
    cyc(0, 0, 4'b0011, 1, 3'd5, 4'b0111, 0, 4'd3);
    cyc(1, 1, 4'b0011, 1, 3'd5, 4'b0111, 0, 4'd3);
    cyc(0, 0, 4'b0000, 1, 3'd0, 4'b0000, 0, 4'd0);

    repeat (3) @(posedge clk_i);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
